// File: rtl/led_sequencer.sv
// LED pattern sequencer: fill, shift and bounce patterns
// stepped by a programmable prescaler.
module led_sequencer #(
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 4,
  parameter int DIV_RESET = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load_div,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] O,
  output logic             done
);

  localparam int SW = $clog2(2*WIDTH);

  localparam logic [1:0] M_FILL   = 2'd0;
  localparam logic [1:0] M_SHIFT  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_PAUSE  = 2'd3;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc;
  logic [SW-1:0]    s;
  logic [SW-1:0]    last;
  logic [1:0]       mode_q;
  logic             done_q;

  logic run;
  logic mode_chg;
  logic tick;
  logic wrap;

  int lvl;
  int idx;

  assign run      = en && (mode != M_PAUSE);
  assign mode_chg = (mode != M_PAUSE) && (mode != mode_q);
  assign tick     = run && !mode_chg && !load_div
                    && (presc == div_q);
  assign wrap     = tick && (s == last);
  assign done     = done_q;

  // last step index of the active pattern
  always_comb begin
    last = SW'(2*WIDTH-1);
    case (mode_q)
      M_SHIFT:  last = SW'(WIDTH-1);
      M_BOUNCE: last = SW'(2*WIDTH-3);
      default:  last = SW'(2*WIDTH-1);
    endcase
  end

  // prescaler, step index, mode and divisor registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q  <= DIV_W'(DIV_RESET);
      presc  <= '0;
      s      <= '0;
      mode_q <= M_FILL;
      done_q <= 1'b0;
    end else begin
      done_q <= wrap;
      if (load_div)
        div_q <= div;
      if (mode_chg) begin
        mode_q <= mode;
        s      <= '0;
      end else if (tick) begin
        s <= wrap ? '0 : s + SW'(1);
      end
      if (load_div || mode_chg || tick)
        presc <= '0;
      else if (run)
        presc <= presc + DIV_W'(1);
    end
  end

  // pattern decode from registered state only
  always_comb begin
    O   = '0;
    lvl = 0;
    idx = 0;
    case (mode_q)
      M_SHIFT:
        idx = WIDTH - 1 - int'(s);
      M_BOUNCE:
        idx = (int'(s) < WIDTH)
              ? WIDTH - 1 - int'(s)
              : int'(s) - WIDTH + 1;
      default:
        lvl = (int'(s) < WIDTH)
              ? int'(s) + 1
              : 2*WIDTH - int'(s);
    endcase
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_q == M_SHIFT || mode_q == M_BOUNCE)
        O[i] = (i == idx);
      else
        O[i] = (i >= WIDTH - lvl);
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer against a
// pattern-table reference model.
module tb_led_sequencer;

  localparam int W = 8;

  logic       CLK;
  logic       RST;
  logic       en;
  logic [1:0] mode;
  logic       load_div;
  logic [3:0] div;
  logic [7:0] O;
  logic       done;

  led_sequencer #(
    .WIDTH(W), .DIV_W(4), .DIV_RESET(0)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .mode(mode),
    .load_div(load_div), .div(div), .O(O), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] o;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  int unsigned pat[3][64];
  int len[3];
  int m_mode, m_pos, m_cnt, m_div;
  logic m_done;
  logic [1:0] cur_md;

  function automatic int unsigned top(input int l);
    return ((1 << W) - 1) ^ ((1 << (W - l)) - 1);
  endfunction

  function void build();
    int k;
    k = 0;
    for (int l = 1; l <= W; l++) begin pat[0][k] = top(l); k++; end
    for (int l = W; l >= 1; l--) begin pat[0][k] = top(l); k++; end
    len[0] = k;
    for (int j = 0; j < W; j++) pat[1][j] = 1 << (W - 1 - j);
    len[1] = W;
    k = 0;
    for (int j = 0; j < W; j++) begin pat[2][k] = 1 << (W-1-j); k++; end
    for (int j = 1; j <= W-2; j++) begin pat[2][k] = 1 << j; k++; end
    len[2] = k;
  endfunction

  function void model_edge(input logic e, input int md,
                           input logic ld, input int dv);
    m_done = 1'b0;
    if (md != 3 && md != m_mode) begin
      m_mode = md;
      m_pos  = 0;
      m_cnt  = 0;
    end else if (md != 3 && e && !ld) begin
      if (m_cnt == m_div) begin
        m_cnt = 0;
        m_pos = m_pos + 1;
        if (m_pos == len[m_mode]) begin
          m_pos  = 0;
          m_done = 1'b1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (ld) begin
      m_div = dv;
      m_cnt = 0;
    end
  endfunction

  // compare every cycle's output with the oldest expectation
  always @(negedge CLK) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (O !== x.o || done !== x.d) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got O=%h done=%b, want O=%h done=%b",
                 $time, O, done, x.o, x.d);
      end
    end
  end

  task automatic step(input logic e, input logic [1:0] md,
                      input logic ld, input logic [3:0] dv);
    en = e; mode = md; load_div = ld; div = dv;
    cur_md = md;
    model_edge(e, int'(md), ld, int'(dv));
    sb.push_back('{8'(pat[m_mode][m_pos]), m_done});
    @(posedge CLK); @(negedge CLK); #1;
    load_div = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [7:0] o,
                     input logic d);
    checks++;
    if (O !== o || done !== d) begin
      errors++;
      $display("FAIL %s: got O=%h done=%b, want O=%h done=%b",
               nm, O, done, o, d);
    end
  endtask

  task automatic rst_hold(input int n);
    RST = 1'b1;
    #1;
    lit("async_reset", 8'h80, 1'b0);
    m_mode = 0; m_pos = 0; m_cnt = 0; m_div = 0; m_done = 1'b0;
    repeat (n) begin
      sb.push_back('{8'h80, 1'b0});
      @(posedge CLK); @(negedge CLK); #1;
    end
    RST = 1'b0;
  endtask

  logic [7:0] fill_v[16] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8,
    8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFC, 8'hF8,
    8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h80};

  initial begin
    int guard;
    build();
    RST = 1'b1; en = 1'b0; mode = 2'd0;
    load_div = 1'b0; div = 4'd0; cur_md = 2'd0;
    #1;
    rst_hold(3);

    // fill sequence, one step per cycle
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'd0, 1'b0, 4'd0);
      lit("fill_seq", fill_v[i], i == 15);
    end

    // shift with divisor 2 plus simultaneous mode change
    step(1'b1, 2'd1, 1'b1, 4'd2);
    lit("shift_load", 8'h80, 1'b0);
    repeat (26) step(1'b1, 2'd1, 1'b0, 4'd0);

    // bounce, one step per cycle
    step(1'b1, 2'd2, 1'b1, 4'd0);
    repeat (30) step(1'b1, 2'd2, 1'b0, 4'd0);

    // freeze with en low, then pause mode
    rst_hold(1);
    repeat (3) step(1'b1, 2'd0, 1'b0, 4'd0);
    lit("fill_at_f0", 8'hF0, 1'b0);
    repeat (5) step(1'b0, 2'd0, 1'b0, 4'd0);
    lit("en_freeze", 8'hF0, 1'b0);
    repeat (5) step(1'b1, 2'd3, 1'b0, 4'd0);
    lit("pause_hold", 8'hF0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 4'd0);
    lit("resume", 8'hF8, 1'b0);

    // mode change mid-fill
    rst_hold(1);
    repeat (3) step(1'b1, 2'd0, 1'b0, 4'd0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    lit("mode_switch", 8'h80, 1'b0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    lit("switch_tick", 8'h40, 1'b0);

    // reset in the middle of a slow shift
    step(1'b1, 2'd1, 1'b1, 4'd5);
    guard = 0;
    while (pat[m_mode][m_pos] != 32'h04 && guard < 200) begin
      step(1'b1, 2'd1, 1'b0, 4'd0);
      guard++;
    end
    lit("shift_at_04", 8'h04, 1'b0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    rst_hold(2);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    lit("post_rst_mode", 8'h80, 1'b0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    lit("post_rst_t1", 8'h40, 1'b0);
    step(1'b1, 2'd1, 1'b0, 4'd0);
    lit("post_rst_t2", 8'h20, 1'b0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic       e, ld;
      logic [1:0] md;
      logic [3:0] dv;
      e  = ($urandom_range(0, 9) != 0);
      md = ($urandom_range(0, 15) == 0)
           ? 2'($urandom_range(0, 3)) : cur_md;
      ld = ($urandom_range(0, 19) == 0);
      dv = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0)
        rst_hold(1);
      else
        step(e, md, ld, dv);
    end

    guard = 0;
    while (sb.size() != 0 && guard < 4) begin
      @(negedge CLK); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
